record_core: RTL

//  Capture path, the write-side counterpart of the mix/playback engine. Accepts 32-bit

---
 rtl/record_if.sv | 20 ++
 rtl/record_core.sv | 133 +++++++++++++
 2 files changed

// File: rtl/record_if.sv
// Capture-path bus: audio sample stream in (valid/ready), single-beat SDRAM writes out.
// master = capture core, slave = audio receiver / SDRAM side.
interface record_if;
    logic        rec_write;
    logic [22:0] rec_addr;
    logic [31:0] rec_writedata;
    logic        rec_sdram_finished;
    logic        rec_audio_valid;
    logic [31:0] rec_audio_data;
    logic        rec_audio_ready;

    modport master (
        output rec_write, rec_addr, rec_writedata, rec_audio_ready,
        input  rec_sdram_finished, rec_audio_valid, rec_audio_data
    );
    modport slave (
        input  rec_write, rec_addr, rec_writedata, rec_audio_ready,
        output rec_sdram_finished, rec_audio_valid, rec_audio_data
    );
endinterface

// File: rtl/record_core.sv
// Recording engine: decimates the incoming stereo stream, buffers kept samples and writes
// them to SDRAM at base+1.., then writes the length header (words + 1) at base on stop.
module record_core #(
    parameter int          DECIM      = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [22:0] MAX_LEN    = 23'h7FFFFE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        rec_start,
    input  logic [22:0] rec_base,
    input  logic        rec_stop,
    output logic        rec_done,
    output logic        rec_overflow,
    record_if.master    bus
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_HEADER, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [22:0]   r_base, r_wptr, r_count;
    logic [PW-1:0] r_phase;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [OW-1:0] r_occ;
    logic          r_write, r_overflow;
    logic [22:0]   r_addr;
    logic [31:0]   r_wdata;

    logic w_ready, w_done, w_start, w_len_full, w_full, w_empty;
    logic w_drain_st, w_push, w_pop, w_accept, w_issue;

    assign w_start    = (r_state == S_IDLE) && rec_start;
    assign w_len_full = (r_count == MAX_LEN);
    assign w_full     = (r_occ == OW'(FIFO_DEPTH));
    assign w_empty    = (r_occ == '0);
    assign w_drain_st = (r_state == S_CAPTURE) || (r_state == S_FLUSH);
    assign w_push     = w_ready && bus.rec_audio_valid && (r_phase == '0) && !w_len_full;
    // The head entry stays in the FIFO until the SDRAM accepts it, so pop on finish.
    assign w_pop      = w_drain_st && r_write && bus.rec_sdram_finished;
    assign w_accept   = w_push && (!w_full || w_pop);
    assign w_issue    = w_drain_st && !r_write && !w_empty && !w_len_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE:    if (rec_start) w_next = S_CAPTURE;
            S_CAPTURE: begin
                w_ready = 1'b1;
                if (rec_stop || w_len_full) w_next = S_FLUSH;
            end
            // Entries beyond MAX_LEN are abandoned; the FIFO is cleared on the next start.
            S_FLUSH:   if (!r_write && (w_empty || w_len_full)) w_next = S_HEADER;
            S_HEADER:  if (r_write && bus.rec_sdram_finished) w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) r_mem[r_wr] <= bus.rec_audio_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_phase    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            if (w_start) begin
                r_base     <= rec_base;
                r_wptr     <= rec_base + 23'd1;
                r_count    <= '0;
                r_phase    <= '0;
                r_rd       <= '0;
                r_wr       <= '0;
                r_occ      <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_ready && bus.rec_audio_valid)
                    r_phase <= (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + PW'(1);
                if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
                if (w_accept) r_wr <= r_wr + AW'(1);
                if (w_pop) begin
                    r_rd    <= r_rd + AW'(1);
                    r_wptr  <= r_wptr + 23'd1;
                    r_count <= r_count + 23'd1;
                end
                r_occ <= r_occ + OW'(w_accept) - OW'(w_pop);
            end
            // Address/data are latched at issue and held until the SDRAM finishes.
            if (r_write) begin
                if (bus.rec_sdram_finished) r_write <= 1'b0;
            end else if (w_issue) begin
                r_write <= 1'b1;
                r_addr  <= r_wptr;
                r_wdata <= r_mem[r_rd];
            end else if (r_state == S_HEADER) begin
                r_write <= 1'b1;
                r_addr  <= r_base;
                r_wdata <= {9'b0, r_count + 23'd1};
            end
        end
    end

    assign bus.rec_write       = r_write;
    assign bus.rec_addr        = r_addr;
    assign bus.rec_writedata   = r_wdata;
    assign bus.rec_audio_ready = w_ready;
    assign rec_overflow        = r_overflow;
    assign rec_done            = w_done;
endmodule
